// File: rtl/spi_arb_pkg.sv
// Shared constants, state encoding and helpers for the SPI bus arbiter.
package spi_arb_pkg;

    localparam int NREQ    = 3;
    localparam int AMP_IDX = 0;
    localparam int ADC_IDX = 1;
    localparam int DAC_IDX = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        if (oh[AMP_IDX]) return 2'(AMP_IDX);
        if (oh[ADC_IDX]) return 2'(ADC_IDX);
        return 2'(DAC_IDX);
    endfunction

endpackage

// File: rtl/spi_arb_pick.sv
// One-hot requester picker: fixed adc > amp > dac, or rotating from the
// index after the last owner when SPI_ARB_ROUND_ROBIN_EN is defined.
module spi_arb_pick
    import spi_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
`ifdef SPI_ARB_ROUND_ROBIN_EN
    input  logic [1:0]      last_idx,
`endif
    output logic [NREQ-1:0] pick
);

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic [1:0] idx;
    logic       found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = 2'((int'(last_idx) + i) % NREQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`else
    always_comb begin
        pick = '0;
        if (req[ADC_IDX])      pick[ADC_IDX] = 1'b1;
        else if (req[AMP_IDX]) pick[AMP_IDX] = 1'b1;
        else if (req[DAC_IDX]) pick[DAC_IDX] = 1'b1;
    end
`endif

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between amp, adc and dac masters with a guard gap and a
// grant watchdog. Optional rotating priority: SPI_ARB_ROUND_ROBIN_EN.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic            CLK50MHZ,
    input  logic            RST,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    input  logic [NREQ-1:0] m_sck,
    input  logic [NREQ-1:0] m_mosi,
    input  logic            amp_cs_i,
    input  logic            dac_cs_i,
    input  logic            ad_conv_i,
    output logic            SPI_SCK,
    output logic            SPI_MOSI,
    output logic            AMP_CS,
    output logic            DAC_CS,
    output logic            AD_CONV,
    output logic            SF_CE0,
    output logic            FPGA_INIT_B,
    output logic            timeout_err,
    output logic [NREQ-1:0] err_src,
    output arb_state_t      dbg_state
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] gnt_d;
    logic [NREQ-1:0] pick;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   wd_cnt;
    logic            wd_hit;
    logic            wd_fire;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic [1:0] last_idx_q;

    spi_arb_pick u_pick (
        .req      (req),
        .last_idx (last_idx_q),
        .pick     (pick)
    );
`else
    spi_arb_pick u_pick (
        .req  (req),
        .pick (pick)
    );
`endif

    // Fires on the TIMEOUT_CYCLES-th cycle of a grant; a zero limit disables it.
    assign wd_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK50MHZ) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        wd_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick;
                end
            end
            ST_GRANT: begin
                // A normal release outranks a watchdog hit in the same cycle.
                if ((|(done & gnt)) || !(|(req & gnt))) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                end else if (wd_hit) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                    wd_fire = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            gnt         <= '0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
            err_src     <= '0;
        end else begin
            gnt         <= gnt_d;
            timeout_err <= wd_fire;
            if (wd_fire) err_src <= gnt;
            if (state_q == ST_GRANT) begin
                if (wd_cnt != TW'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + TW'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (state_q == ST_RELEASE) gap_cnt <= gap_cnt + GW'(1);
            else                       gap_cnt <= '0;
        end
    end

`ifdef SPI_ARB_ROUND_ROBIN_EN
    always_ff @(posedge CLK50MHZ) begin
        if (RST)                             last_idx_q <= 2'(DAC_IDX);
        else if (state_q == ST_IDLE && |req) last_idx_q <= onehot_to_idx(pick);
    end
`endif

    // Pin gating uses only the registered grant, so non-owners never reach the bus.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        SPI_SCK  = |(gnt & m_sck);
        SPI_MOSI = |(gnt & m_mosi);
        AMP_CS   = ~gnt[AMP_IDX] | amp_cs_i;
        DAC_CS   = ~gnt[DAC_IDX] | dac_cs_i;
        AD_CONV  = gnt[ADC_IDX] & ad_conv_i;
    end

    assign SF_CE0      = 1'b1;
    assign FPGA_INIT_B = 1'b1;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter; follows SPI_ARB_ROUND_ROBIN_EN in its model.
module tb_spi_bus_arbiter;
    import spi_arb_pkg::*;

    localparam int GAP = 2;
    localparam int TMO = 16;

    logic       CLK50MHZ = 1'b0;
    logic       RST      = 1'b1;
    logic [2:0] req      = '0;
    logic [2:0] done     = '0;
    logic [2:0] m_sck    = '0;
    logic [2:0] m_mosi   = '0;
    logic       amp_cs_i = 1'b1;
    logic       dac_cs_i = 1'b1;
    logic       ad_conv_i = 1'b0;

    logic [2:0] gnt, err_src;
    logic       busy, SPI_SCK, SPI_MOSI, AMP_CS, DAC_CS, AD_CONV;
    logic       SF_CE0, FPGA_INIT_B, timeout_err;
    arb_state_t dbg_state;

    int cmp_cnt    = 0;
    int fail_cnt   = 0;
    int last_owner = DAC_IDX;

    spi_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK50MHZ(CLK50MHZ), .RST(RST), .req(req), .done(done), .gnt(gnt),
        .busy(busy), .m_sck(m_sck), .m_mosi(m_mosi), .amp_cs_i(amp_cs_i),
        .dac_cs_i(dac_cs_i), .ad_conv_i(ad_conv_i), .SPI_SCK(SPI_SCK),
        .SPI_MOSI(SPI_MOSI), .AMP_CS(AMP_CS), .DAC_CS(DAC_CS), .AD_CONV(AD_CONV),
        .SF_CE0(SF_CE0), .FPGA_INIT_B(FPGA_INIT_B), .timeout_err(timeout_err),
        .err_src(err_src), .dbg_state(dbg_state)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    // Arbitration rule as stated: fixed adc > amp > dac, or first requester after last owner.
    function automatic logic [2:0] model_pick(input logic [2:0] r, input int last);
        logic [2:0] res;
        res = '0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= 3; i++) begin
            int j;
            j = (last + i) % 3;
            if (res == 3'b000 && r[j]) res[j] = 1'b1;
        end
`else
        if (r[1])      res = 3'b010;
        else if (r[0]) res = 3'b001;
        else if (r[2]) res = 3'b100;
`endif
        return res;
    endfunction

    function automatic int idx_of(input logic [2:0] oh);
        return oh[0] ? 0 : (oh[1] ? 1 : 2);
    endfunction

    task automatic tick();
        @(posedge CLK50MHZ);
        #5;
    endtask

    task automatic test_reset();
        RST = 1'b1; m_sck = 3'b111; m_mosi = 3'b111;
        amp_cs_i = 1'b0; dac_cs_i = 1'b0; ad_conv_i = 1'b1;
        tick(); tick();
        cmp_cnt++;
        if ({gnt, busy, timeout_err, err_src} !== 8'b000_0_0_000) begin
            fail_cnt++;
            $display("FAIL reset_regs: got %b required %b", {gnt, busy, timeout_err, err_src}, 8'b0);
        end
        cmp_cnt++;
        if ({SPI_SCK, SPI_MOSI, AMP_CS, DAC_CS, AD_CONV, SF_CE0, FPGA_INIT_B} !== 7'b0011011) begin
            fail_cnt++;
            $display("FAIL reset_pins: got %b required %b",
                     {SPI_SCK, SPI_MOSI, AMP_CS, DAC_CS, AD_CONV, SF_CE0, FPGA_INIT_B}, 7'b0011011);
        end
        cmp_cnt++;
        if (dbg_state !== ST_IDLE) begin
            fail_cnt++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
        m_sck = '0; m_mosi = '0; amp_cs_i = 1'b1; dac_cs_i = 1'b1; ad_conv_i = 1'b0;
        RST = 1'b0; last_owner = DAC_IDX;
        tick();
    endtask

    task automatic test_single_amp();
        req = 3'b001;
        tick();
        cmp_cnt++;
        if ({gnt, busy} !== 4'b001_1) begin
            fail_cnt++;
            $display("FAIL amp_grant: got gnt=%b busy=%b required gnt=001 busy=1", gnt, busy);
        end
        last_owner = AMP_IDX;
        amp_cs_i = 1'b0; dac_cs_i = 1'b0; ad_conv_i = 1'b1;
        #1;
        cmp_cnt++;
        if ({AMP_CS, DAC_CS, AD_CONV} !== 3'b010) begin
            fail_cnt++;
            $display("FAIL amp_cs_low: got %b required 010", {AMP_CS, DAC_CS, AD_CONV});
        end
        amp_cs_i = 1'b1; dac_cs_i = 1'b1; ad_conv_i = 1'b0;
        #1;
        cmp_cnt++;
        if (AMP_CS !== 1'b1) begin
            fail_cnt++;
            $display("FAIL amp_cs_high: got %b required 1", AMP_CS);
        end
        done = 3'b001; req = 3'b000;
        tick();
        done = 3'b000;
        cmp_cnt++;
        if (gnt !== 3'b000) begin
            fail_cnt++;
            $display("FAIL amp_release: got %b required 000", gnt);
        end
        tick(); tick();
        cmp_cnt++;
        if (busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL amp_idle: got busy=%b required 0", busy);
        end
    endtask

    // All three request together, each drops its request with its done.
    task automatic test_priority();
        logic [2:0] r, exp_g;
        r = 3'b111; req = r;
        tick();
        for (int n = 0; n < 3; n++) begin
            exp_g = model_pick(r, last_owner);
            cmp_cnt++;
            if (gnt !== exp_g) begin
                fail_cnt++;
                $display("FAIL prio_grant%0d: got %b required %b", n, gnt, exp_g);
            end
            last_owner = idx_of(exp_g);
            done = exp_g | ~exp_g;
            done = exp_g;
            r = r & ~exp_g; req = r;
            tick();
            done = '0;
            for (int g = 0; g <= GAP; g++) begin
                cmp_cnt++;
                if (gnt !== 3'b000 || SPI_SCK !== 1'b0) begin
                    fail_cnt++;
                    $display("FAIL prio_gap%0d_%0d: got gnt=%b sck=%b required 000/0", n, g, gnt, SPI_SCK);
                end
                tick();
            end
        end
        cmp_cnt++;
        if (busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL prio_idle: got busy=%b required 0", busy);
        end
    endtask

    // Requests stay asserted across done, so each master re-arbitrates after the gap.
    task automatic test_repeat();
        logic [2:0] exp_g;
        req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            tick();
            exp_g = model_pick(3'b111, last_owner);
            cmp_cnt++;
            if (gnt !== exp_g) begin
                fail_cnt++;
                $display("FAIL repeat_grant%0d: got %b required %b", n, gnt, exp_g);
            end
            last_owner = idx_of(exp_g);
            done = exp_g;
            tick();
            done = '0;
            cmp_cnt++;
            if (gnt !== 3'b000) begin
                fail_cnt++;
                $display("FAIL repeat_release%0d: got %b required 000", n, gnt);
            end
            for (int g = 0; g < GAP; g++) tick();
        end
        req = '0;
        tick();
    endtask

    task automatic test_watchdog();
        req = 3'b100;
        tick();
        last_owner = DAC_IDX;
        for (int k = 1; k < TMO; k++) begin
            tick();
            cmp_cnt++;
            if ({gnt, timeout_err} !== 4'b100_0) begin
                fail_cnt++;
                $display("FAIL wd_hold%0d: got gnt=%b terr=%b required 100/0", k, gnt, timeout_err);
            end
        end
        tick();
        cmp_cnt++;
        if ({gnt, timeout_err, err_src} !== 7'b000_1_100) begin
            fail_cnt++;
            $display("FAIL wd_fire: got gnt=%b terr=%b src=%b required 000/1/100", gnt, timeout_err, err_src);
        end
        req = '0;
        tick();
        cmp_cnt++;
        if ({timeout_err, err_src} !== 4'b0_100) begin
            fail_cnt++;
            $display("FAIL wd_pulse: got terr=%b src=%b required 0/100", timeout_err, err_src);
        end
        tick();
        cmp_cnt++;
        if (busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL wd_idle: got busy=%b required 0", busy);
        end
    endtask

    // done lands on the very cycle the watchdog would fire.
    task automatic test_done_timeout();
        req = 3'b100;
        tick();
        last_owner = DAC_IDX;
        for (int k = 1; k < TMO; k++) tick();
        done = 3'b100; req = '0;
        tick();
        done = '0;
        cmp_cnt++;
        if ({gnt, timeout_err, err_src} !== 7'b000_0_100) begin
            fail_cnt++;
            $display("FAIL done_vs_wd: got gnt=%b terr=%b src=%b required 000/0/100", gnt, timeout_err, err_src);
        end
        tick(); tick();
    endtask

    task automatic test_gating();
        req = 3'b001;
        tick();
        last_owner = AMP_IDX;
        m_sck = 3'b100; m_mosi = 3'b110; dac_cs_i = 1'b0; ad_conv_i = 1'b1;
        #1;
        cmp_cnt++;
        if ({SPI_SCK, SPI_MOSI, DAC_CS, AD_CONV} !== 4'b0010) begin
            fail_cnt++;
            $display("FAIL gate_nonowner: got %b required 0010", {SPI_SCK, SPI_MOSI, DAC_CS, AD_CONV});
        end
        m_sck = 3'b101; m_mosi = 3'b111;
        #1;
        cmp_cnt++;
        if ({SPI_SCK, SPI_MOSI} !== 2'b11) begin
            fail_cnt++;
            $display("FAIL gate_owner: got %b required 11", {SPI_SCK, SPI_MOSI});
        end
        m_sck = '0; m_mosi = '0; dac_cs_i = 1'b1; ad_conv_i = 1'b0;
        done = 3'b001; req = '0;
        tick();
        done = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        req = 3'b010;
        tick();
        ad_conv_i = 1'b1;
        #1;
        cmp_cnt++;
        if ({gnt, AD_CONV} !== 4'b010_1) begin
            fail_cnt++;
            $display("FAIL rst_mid_pre: got gnt=%b conv=%b required 010/1", gnt, AD_CONV);
        end
        RST = 1'b1;
        tick();
        cmp_cnt++;
        if ({gnt, AD_CONV, busy} !== 5'b000_0_0) begin
            fail_cnt++;
            $display("FAIL rst_mid: got gnt=%b conv=%b busy=%b required 000/0/0", gnt, AD_CONV, busy);
        end
        RST = 1'b0; req = '0; ad_conv_i = 1'b0; last_owner = DAC_IDX;
        tick();
    endtask

    // Random request sets, hold lengths, release style, stray done bits and pin traffic.
    task automatic test_random();
        logic [2:0] r, exp_g;
        logic [4:0] exp_bus;
        int o, hold;
        for (int t = 0; t < 25; t++) begin
            r = 3'($urandom_range(1, 7)); req = r;
            tick();
            while (r != 3'b000) begin
                exp_g = model_pick(r, last_owner);
                o = idx_of(exp_g);
                cmp_cnt++;
                if (gnt !== exp_g) begin
                    fail_cnt++;
                    $display("FAIL rnd_grant%0d: req=%b got %b required %b", t, r, gnt, exp_g);
                end
                last_owner = o;
                hold = $urandom_range(0, 6);
                for (int h = 0; h < hold; h++) begin
                    m_sck = 3'($urandom_range(0, 7)); m_mosi = 3'($urandom_range(0, 7));
                    amp_cs_i = 1'($urandom_range(0, 1)); dac_cs_i = 1'($urandom_range(0, 1));
                    ad_conv_i = 1'($urandom_range(0, 1));
                    done = 3'($urandom_range(0, 7)) & ~exp_g;
                    #1;
                    exp_bus = {m_sck[o], m_mosi[o], (o == 0) ? amp_cs_i : 1'b1,
                               (o == 2) ? dac_cs_i : 1'b1, (o == 1) & ad_conv_i};
                    cmp_cnt++;
                    if ({SPI_SCK, SPI_MOSI, AMP_CS, DAC_CS, AD_CONV} !== exp_bus) begin
                        fail_cnt++;
                        $display("FAIL rnd_bus%0d: got %b required %b", t,
                                 {SPI_SCK, SPI_MOSI, AMP_CS, DAC_CS, AD_CONV}, exp_bus);
                    end
                    tick();
                    cmp_cnt++;
                    if (gnt !== exp_g) begin
                        fail_cnt++;
                        $display("FAIL rnd_hold%0d: got %b required %b", t, gnt, exp_g);
                    end
                end
                done = ($urandom_range(0, 1) == 1) ? exp_g : 3'b000;
                r = r & ~exp_g; req = r;
                tick();
                done = '0;
                for (int g = 0; g <= GAP; g++) begin
                    m_sck = 3'b111; m_mosi = 3'b111; amp_cs_i = 1'b0; dac_cs_i = 1'b0; ad_conv_i = 1'b1;
                    #1;
                    cmp_cnt++;
                    if ({gnt, SPI_SCK, SPI_MOSI, AMP_CS, DAC_CS, AD_CONV} !== 8'b000_0_0_1_1_0) begin
                        fail_cnt++;
                        $display("FAIL rnd_gap%0d_%0d: got %b required 00000110", t, g,
                                 {gnt, SPI_SCK, SPI_MOSI, AMP_CS, DAC_CS, AD_CONV});
                    end
                    tick();
                end
            end
        end
        m_sck = '0; m_mosi = '0; amp_cs_i = 1'b1; dac_cs_i = 1'b1; ad_conv_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_amp();
        test_priority();
        test_repeat();
        test_watchdog();
        test_done_timeout();
        test_gating();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
